// File: rtl/chip8_pkg.sv
// Shared constants and helpers for the CHIP-8 timebase.
package chip8_pkg;

   localparam int TIMER_W           = 8;
   localparam int DEFAULT_INSTR_DIV = 142857;
   localparam int DEFAULT_TIMER_DIV = 1666667;

   // 60 Hz timers count down to zero and rest there
   function automatic logic [TIMER_W-1:0] tmr_dec(
      input logic [TIMER_W-1:0] v
   );
      return (v == '0) ? '0 : v - TIMER_W'(1);
   endfunction

endpackage

// File: rtl/chip8_strobe_div.sv
// Free-running divider: one-cycle terminal pulse every DIV enabled cycles.
module chip8_strobe_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic pulse
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   assign pulse = enable && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (enable) begin
         count <= pulse ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/chip8_timebase.sv
// Instruction strobe, 60 Hz tick and delay/sound timers for a CHIP-8 core.
module chip8_timebase
   import chip8_pkg::*;
#(
   parameter int INSTR_DIV = DEFAULT_INSTR_DIV,
   parameter int TIMER_DIV = DEFAULT_TIMER_DIV
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               active_in,
   input  logic               step_in,
   input  logic               proc_ready_in,
   input  logic               dt_we_in,
   input  logic               st_we_in,
   input  logic [TIMER_W-1:0] timer_data_in,
   output logic               chip8_clk_out,
   output logic               timer_tick_out,
   output logic [TIMER_W-1:0] dt_out,
   output logic [TIMER_W-1:0] st_out,
   output logic               sound_out,
   output logic [7:0]         missed_out
);

   logic instr_tc;
   logic timer_tc;
   logic pending;
   logic req;
   logic issue;
   logic [TIMER_W-1:0] dt_nxt;
   logic [TIMER_W-1:0] st_nxt;

   chip8_strobe_div #(.DIV(INSTR_DIV)) u_instr_div (
      .clk    (clk_in),
      .rst_n  (rst_in),
      .enable (active_in),
      .pulse  (instr_tc)
   );

   chip8_strobe_div #(.DIV(TIMER_DIV)) u_timer_div (
      .clk    (clk_in),
      .rst_n  (rst_in),
      .enable (active_in),
      .pulse  (timer_tc)
   );

   assign req   = instr_tc | (step_in & ~active_in);
   assign issue = pending & proc_ready_in;

   // a load beats a coincident tick
   always_comb begin
      dt_nxt = dt_out;
      st_nxt = st_out;
      if (dt_we_in) begin
         dt_nxt = timer_data_in;
      end else if (timer_tc) begin
         dt_nxt = tmr_dec(dt_out);
      end
      if (st_we_in) begin
         st_nxt = timer_data_in;
      end else if (timer_tc) begin
         st_nxt = tmr_dec(st_out);
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pending        <= 1'b0;
         chip8_clk_out  <= 1'b0;
         timer_tick_out <= 1'b0;
         dt_out         <= '0;
         st_out         <= '0;
         sound_out      <= 1'b0;
         missed_out     <= '0;
      end else begin
         pending        <= req | (pending & ~issue);
         chip8_clk_out  <= issue;
         timer_tick_out <= timer_tc;
         dt_out         <= dt_nxt;
         st_out         <= st_nxt;
         sound_out      <= (st_nxt != '0);
         if (req && pending && !issue && missed_out != 8'hFF) begin
            missed_out <= missed_out + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_chip8_timebase.sv
// Directed and randomized checks of chip8_timebase against a cycle model.
module tb_chip8_timebase;

   localparam int ID = 4;
   localparam int TD = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       active = 1'b0;
   logic       step = 1'b0;
   logic       ready = 1'b0;
   logic       dt_we = 1'b0;
   logic       st_we = 1'b0;
   logic [7:0] tdata = 8'd0;
   logic       c8clk;
   logic       tick;
   logic [7:0] dt;
   logic [7:0] st;
   logic       sound;
   logic [7:0] missed;

   always #5 clk = ~clk;

   chip8_timebase #(.INSTR_DIV(ID), .TIMER_DIV(TD)) dut (
      .clk_in         (clk),
      .rst_in         (rst_n),
      .active_in      (active),
      .step_in        (step),
      .proc_ready_in  (ready),
      .dt_we_in       (dt_we),
      .st_we_in       (st_we),
      .timer_data_in  (tdata),
      .chip8_clk_out  (c8clk),
      .timer_tick_out (tick),
      .dt_out         (dt),
      .st_out         (st),
      .sound_out      (sound),
      .missed_out     (missed)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // model: active edges seen by each divider, plus output state
   int m_ia, m_ta, m_pend, m_clk, m_tick, m_dt, m_st, m_missed;
   bit cmp_en = 1'b0;

   task automatic model_reset();
      m_ia = 0; m_ta = 0; m_pend = 0; m_clk = 0;
      m_tick = 0; m_dt = 0; m_st = 0; m_missed = 0;
   endtask

   initial model_reset();

   always @(posedge clk) begin
      bit itc, ttc, rq, iss;
      if (rst_n) begin
         itc = active && (m_ia % ID == ID - 1);
         ttc = active && (m_ta % TD == TD - 1);
         rq  = itc || (step && !active);
         iss = (m_pend != 0) && ready;
         if (rq && m_pend != 0 && !iss && m_missed < 255) m_missed++;
         m_clk  = iss;
         m_pend = (rq || (m_pend != 0 && !iss)) ? 1 : 0;
         m_tick = ttc;
         if (dt_we) m_dt = tdata;
         else if (ttc && m_dt > 0) m_dt--;
         if (st_we) m_st = tdata;
         else if (ttc && m_st > 0) m_st--;
         if (active) begin
            m_ia++;
            m_ta++;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("clk_out", c8clk, m_clk);
         chk("tick", tick, m_tick);
         chk("dt", dt, m_dt);
         chk("st", st, m_st);
         chk("sound", sound, (m_st != 0));
         chk("missed", missed, m_missed);
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_clk"}, c8clk, 0);
      chk({tag, "_tick"}, tick, 0);
      chk({tag, "_dt"}, dt, 0);
      chk({tag, "_st"}, st, 0);
      chk({tag, "_snd"}, sound, 0);
      chk({tag, "_miss"}, missed, 0);
   endtask

   // async assert between edges, release on a falling edge
   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1 chk_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_tick(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick && n < 3 * TD);
      if (!tick) chk({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      int mask, cnt, first, sdt, sst, n;

      // reset state and nominal strobe cadence
      active = 1'b1;
      ready  = 1'b1;
      @(negedge clk);
      cmp_en = 1'b1;
      chk_zero("init");
      rst_n = 1'b1;
      mask = 0;
      for (int e = 1; e <= 13; e++) begin
         @(negedge clk);
         if (c8clk) mask |= (1 << e);
      end
      chk("strobe_edges", mask, (1 << 5) | (1 << 9) | (1 << 13));
      chk("no_miss", missed, 0);

      // processor stalled for ten edges
      ready = 1'b0;
      do_reset();
      cnt = 0;
      first = 0;
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         if (c8clk) begin
            cnt++;
            if (first == 0) first = e;
         end
         if (e == 10) ready = 1'b1;
      end
      chk("stall_first", first, 11);
      chk("stall_count", cnt, 1);
      chk("stall_miss", missed, 1);

      // delay timer countdown
      dt_we = 1'b1;
      tdata = 8'd3;
      @(negedge clk);
      dt_we = 1'b0;
      chk("dt_load", dt, 3);
      for (int k = 2; k >= 0; k--) begin
         wait_tick("dt");
         chk("dt_down", dt, k);
      end
      wait_tick("dt");
      chk("dt_floor", dt, 0);

      // sound timer load colliding with a tick
      n = 0;
      while (!(m_ta % TD == TD - 1) && n < 3 * TD) begin
         @(negedge clk);
         n++;
      end
      st_we = 1'b1;
      tdata = 8'd2;
      @(negedge clk);
      st_we = 1'b0;
      chk("st_coll_tick", tick, 1);
      chk("st_coll_val", st, 2);
      chk("st_coll_snd", sound, 1);
      wait_tick("st");
      chk("st_1", st, 1);
      wait_tick("st");
      chk("st_0", st, 0);
      chk("snd_off", sound, 0);

      // single step while halted
      dt_we = 1'b1;
      tdata = 8'd9;
      @(negedge clk);
      dt_we = 1'b0;
      active = 1'b0;
      repeat (3) @(negedge clk);
      sdt = dt;
      sst = st;
      step = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         step = 1'b0;
         if (c8clk) cnt++;
      end
      chk("step_count", cnt, 1);
      chk("step_dt", dt, sdt);
      chk("step_st", st, sst);

      // reset with a strobe pending and sound running
      active = 1'b1;
      ready  = 1'b0;
      repeat (5) @(negedge clk);
      st_we = 1'b1;
      tdata = 8'd5;
      @(negedge clk);
      st_we = 1'b0;
      chk("pre_rst_st", st, 5);
      chk("pre_rst_snd", sound, 1);
      ready = 1'b1;
      do_reset();
      first = 0;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         if (c8clk && first == 0) first = e;
      end
      chk("post_rst_first", first, 5);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         active = ($urandom_range(0, 9) != 0);
         step   = ($urandom_range(0, 4) == 0);
         ready  = ($urandom_range(0, 9) < 7);
         dt_we  = active && ($urandom_range(0, 19) == 0);
         st_we  = active && ($urandom_range(0, 19) == 0);
         tdata  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      // missed counter saturation
      active = 1'b1;
      step   = 1'b0;
      dt_we  = 1'b0;
      st_we  = 1'b0;
      ready  = 1'b0;
      do_reset();
      repeat (1100) @(negedge clk);
      chk("miss_sat", missed, 255);
      repeat (8) @(negedge clk);
      chk("miss_hold", missed, 255);

      @(negedge clk);
      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chip8_timebase.md
CHIP8_TIMEBASE -- requirements
Module: chip8_timebase

Interface
REQ-001 SHALL have parameter INSTR_DIV, default 142857, meaning clk_in cycles per instruction strobe (700 Hz at 100 MHz).
REQ-002 SHALL have parameter TIMER_DIV, default 1666667, meaning clk_in cycles per 60 Hz timer tick.
REQ-003 SHALL have port clk_in, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port active_in, input, 1 bit: run enable; when low, both dividers freeze.
REQ-006 SHALL have port step_in, input, 1 bit: single-step request, honoured only while active_in is low.
REQ-007 SHALL have port proc_ready_in, input, 1 bit: the processor can accept an instruction strobe.
REQ-008 SHALL have port dt_we_in, input, 1 bit: load the delay timer from timer_data_in.
REQ-009 SHALL have port st_we_in, input, 1 bit: load the sound timer from timer_data_in.
REQ-010 SHALL have port timer_data_in, input, 8 bits: the load value for either timer.
REQ-011 SHALL have port chip8_clk_out, output, 1 bit: one-cycle instruction strobe, driving the processor's chip8_clk_in.
REQ-012 SHALL have port timer_tick_out, output, 1 bit: one-cycle 60 Hz pulse.
REQ-013 SHALL have port dt_out, output, 8 bits: current delay timer value.
REQ-014 SHALL have port st_out, output, 8 bits: current sound timer value.
REQ-015 SHALL have port sound_out, output, 1 bit: beeper enable.
REQ-016 SHALL have port missed_out, output, 8 bits: saturating count of dropped instruction strobes.

Function
REQ-017 Instruction divider SHALL count 0..INSTR_DIV-1 while active_in=1, wrap to 0, and set the internal pending flag on its terminal count.
REQ-018 While active_in=0, a step_in=1 cycle SHALL set pending; step_in SHALL be ignored while active_in=1.
REQ-019 When pending=1 and proc_ready_in=1, the block SHALL assert chip8_clk_out for exactly the next cycle and clear pending (registered output, 1-cycle latency).
REQ-020 If the clear of pending and a new terminal count/step occur in the same cycle, pending SHALL remain 1.
REQ-021 If a terminal count occurs while pending=1 and pending is not being issued, missed_out SHALL increment, saturating at 255.
REQ-022 Timer divider SHALL count 0..TIMER_DIV-1 while active_in=1; timer_tick_out SHALL be high for the one cycle after the terminal count.
REQ-023 On each tick, dt_out and st_out SHALL each decrement by 1 if nonzero; a zero value SHALL stay 0 (no wrap).
REQ-024 dt_we_in/st_we_in SHALL load timer_data_in on the next edge; a write SHALL take priority over a coincident tick (no decrement that cycle).
REQ-025 Simultaneous dt_we_in and st_we_in SHALL load both timers.
REQ-026 sound_out SHALL be registered, equal to (st_out != 0), and lag st_out by 0 cycles.
REQ-027 Dropping active_in SHALL hold counters, timers and pending; raising it SHALL resume counting from the held counts.

Reset
REQ-028 rst_in=0 SHALL immediately, without a clock edge, force both counters, pending, chip8_clk_out, timer_tick_out, dt_out, st_out, sound_out and missed_out to 0.
REQ-029 Reset asserted mid-count or with pending=1 SHALL discard the pending strobe; the first strobe after release SHALL follow the full INSTR_DIV period.

Structure
REQ-030 chip8_pkg SHALL hold TIMER_W=8, DEFAULT_INSTR_DIV and DEFAULT_TIMER_DIV.
REQ-031 Counter widths SHALL be $clog2 of the respective divider.
REQ-032 Each divider SHALL be one instance of sub-module chip8_strobe_div (parameter DIV; inputs enable and async reset; output a one-cycle terminal pulse).

Verification (INSTR_DIV=4, TIMER_DIV=10)
REQ-033 Release reset with active_in=1 and proc_ready_in=1 -> chip8_clk_out high in the cycles following edges 5, 9 and 13; missed_out=0.
REQ-034 Hold proc_ready_in=0 for edges 1-10, then raise it -> a single strobe after edge 11 and missed_out=1.
REQ-035 Write dt=3 -> dt_out goes 3,2,1,0 on successive ticks, then stays 0.
REQ-036 Write st=2 coincident with a tick -> st_out=2 and sound_out=1; after two further ticks st_out=0 and sound_out=0.
REQ-037 Set active_in=0 and pulse step_in once -> exactly one chip8_clk_out; the timers do not change.
REQ-038 Assert rst_in=0 between clock edges while pending=1 and st_out=5 -> all outputs 0 before the next edge; no strobe after release until edge 5.
